// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle ARM-subset control FSM; define MCCTRL_MEMWAIT_EN to add the MemReady wait handshake
module multicycle_controller #(
  parameter logic [3:0] NZCV_INIT = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
`ifdef MCCTRL_MEMWAIT_EN
  input  logic        MemReady,
`endif
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        ALUSrcA,
  output logic        Shift,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;
  state_t state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic n, z, c, v;
  logic cond_ex, mem_rdy, no_write, is_mov;
  logic [2:0] dp_ctrl;
  logic pc_write, ir_write, reg_write, mem_write;
  logic unused;
  assign {cond, op, funct} = Instr[19:8];
  assign rd = Instr[3:0];
  assign unused = ^Instr[7:4];
  assign {n, z, c, v} = flags_q;
`ifdef MCCTRL_MEMWAIT_EN
  assign mem_rdy = MemReady;
`else
  assign mem_rdy = 1'b1;
`endif
  // ARM condition evaluation against the registered flags; 1111 never executes
  always_comb begin
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = n ~^ v;
      4'b1011: cond_ex = n ^ v;
      4'b1100: cond_ex = ~z & (n ~^ v);
      4'b1101: cond_ex = z | (n ^ v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // data-processing opcode decode; unknown opcodes become a non-writing ADD
  always_comb begin
    dp_ctrl = 3'b000;
    no_write = 1'b0;
    is_mov = 1'b0;
    case (funct[4:1])
      4'b0100: dp_ctrl = 3'b000;
      4'b0010: dp_ctrl = 3'b001;
      4'b0000: dp_ctrl = 3'b010;
      4'b1100: dp_ctrl = 3'b011;
      4'b0001: dp_ctrl = 3'b100;
      4'b1010: begin dp_ctrl = 3'b001; no_write = 1'b1; end
      4'b1101: is_mov = 1'b1;
      default: no_write = 1'b1;
    endcase
  end
  assign flags_d = ((state_q == EXECUTER || state_q == EXECUTEI) && funct[0] && cond_ex) ? ALUFlags : flags_q;
  // state and flags registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      flags_q <= NZCV_INIT;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end
  // next-state and Moore outputs; memory states stall until the memory is ready
  always_comb begin
    state_d = FETCH;
    pc_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    AdrSrc = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ResultSrc = 2'b00;
    ALUControl = 3'b000;
    Shift = 1'b0;
    case (state_q)
      FETCH: begin
        state_d = mem_rdy ? DECODE : FETCH;
        ir_write = mem_rdy;
        pc_write = mem_rdy;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        state_d = op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH : op == 2'b11 ? FETCH : funct[5] ? EXECUTEI : EXECUTER;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        state_d = funct[0] ? MEMREAD : MEMWRITE;
        ALUSrcB = 2'b01;
        ALUControl = funct[3] ? 3'b000 : 3'b001;
      end
      MEMREAD: begin
        state_d = mem_rdy ? MEMWB : MEMREAD;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = cond_ex;
        pc_write = cond_ex && rd == 4'hF;
      end
      MEMWRITE: begin
        state_d = mem_rdy ? FETCH : MEMWRITE;
        AdrSrc = 1'b1;
        mem_write = cond_ex && mem_rdy;
      end
      EXECUTER, EXECUTEI: begin
        state_d = ALUWB;
        ALUSrcB = {1'b0, state_q == EXECUTEI};
        ALUControl = dp_ctrl;
        Shift = is_mov;
      end
      ALUWB: begin
        reg_write = cond_ex && !no_write;
        pc_write = cond_ex && !no_write && rd == 4'hF;
        ALUControl = dp_ctrl;
        Shift = is_mov;
      end
      BRANCH: begin
        ALUSrcB = 2'b01;
        ResultSrc = 2'b10;
        pc_write = cond_ex;
      end
      default: state_d = FETCH;
    endcase
  end
  assign PCWrite = reset & pc_write;
  assign IRWrite = reset & ir_write;
  assign RegWrite = reset & reg_write;
  assign MemWrite = reset & mem_write;
  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign State = state_q;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter NZCV_INIT, default 4'b0000, meaning the reset value of the internal flags register {N,Z,C,V}.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port Instr  input  20  instruction bits [31:12]: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
REQ-005 The block SHALL have port ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-006 The block SHALL have outputs PCWrite, IRWrite, AdrSrc, RegWrite, MemWrite, ALUSrcA, Shift (each 1 bit), and RegSrc, ImmSrc, ALUSrcB, ResultSrc (each 2 bits), and ALUControl (3 bits), and State (4 bits, debug).

Function
REQ-007 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; encodings 10-15 SHALL go to FETCH.
REQ-008 The transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECUTER (Op=00, Funct[5]=0), EXECUTEI (Op=00, Funct[5]=1), BRANCH (Op=10), or FETCH (Op=11, NOP).
REQ-009 The remaining transitions SHALL be: MEMADR->MEMREAD (Funct[0]=1) or MEMWRITE (Funct[0]=0); MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB and BRANCH->FETCH.
REQ-010 Latency SHALL be 5 cycles for LDR, 4 for STR, 4 for data-processing, 3 for B, and 2 for Op=11.
REQ-011 In FETCH the outputs SHALL be AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1; DECODE SHALL use the same ALU settings with no write strobes.
REQ-012 In MEMADR the outputs SHALL be ALUSrcA=0, ALUSrcB=01, and ALUControl=ADD if Funct[3]=1, else SUB.
REQ-013 MEMREAD SHALL drive AdrSrc=1 and ResultSrc=00; MEMWRITE SHALL drive AdrSrc=1 and MemWrite=CondEx.
REQ-014 MEMWB SHALL drive ResultSrc=01 and RegWrite=CondEx; EXECUTER SHALL drive ALUSrcA=0 and ALUSrcB=00; EXECUTEI SHALL drive ALUSrcA=0 and ALUSrcB=01.
REQ-015 ALUWB SHALL drive ResultSrc=00 and RegWrite=CondEx&~NoWrite; BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=CondEx.
REQ-016 In MEMWB or ALUWB with Rd=4'b1111, PCWrite SHALL equal RegWrite.
REQ-017 ALUControl in EXECUTE states SHALL decode Funct[4:1] as: 0100 ADD=000, 0010 SUB=001, 0000 AND=010, 1100 ORR=011, 0001 EOR=100, 1010 CMP (SUB, NoWrite=1), 1101 MOV (ADD, Shift=1); any other code SHALL be ADD with NoWrite=1.
REQ-018 Shift SHALL be 1 only for MOV in EXECUTER, EXECUTEI and ALUWB.
REQ-019 ImmSrc SHALL equal Op, and RegSrc SHALL be {Op==01, Op==10}, in every state.
REQ-020 CondEx SHALL be computed combinationally from Cond and the registered flags per ARM codes 0000-1110; Cond=1111 SHALL give CondEx=0.
REQ-021 The flags register SHALL load ALUFlags on the edge leaving EXECUTER/EXECUTEI only when Funct[0]=1 and CondEx=1.
REQ-022 A condition that fails SHALL still traverse all states while suppressing RegWrite, MemWrite and the branch PCWrite; the FETCH PCWrite SHALL always occur.

Reset
REQ-023 While reset=0, the block SHALL hold State=FETCH and flags=NZCV_INIT and SHALL force PCWrite, IRWrite, RegWrite and MemWrite to 0.
REQ-024 Reset asserted mid-instruction SHALL abort it at once, with no pending write issued.
REQ-025 The first edge after reset deasserts SHALL perform a normal FETCH.

Configuration
REQ-026 Macro MCCTRL_MEMWAIT_EN SHALL control the memory-wait feature.
REQ-027 When MCCTRL_MEMWAIT_EN is defined, the block SHALL add input MemReady (1 bit); FETCH, MEMREAD and MEMWRITE SHALL hold their state while MemReady=0, with IRWrite, PCWrite and MemWrite asserted only in the cycle MemReady=1.
REQ-028 When MCCTRL_MEMWAIT_EN is undefined, the MemReady port SHALL be absent and memory SHALL be treated as always ready.

Verification
REQ-029 Scenario: ADD R1,R2,R3 (Instr[31:12]=0xE0821) -> States 0,1,6,8; in state 8 RegWrite=1 and ALUControl=000.
REQ-030 Scenario: LDR (Op=01, Funct=011001) -> States 0,1,2,3,4; in state 4 ResultSrc=01 and RegWrite=1.
REQ-031 Scenario: SUBS giving Z=1, then BEQ (Cond=0000) -> BRANCH asserts PCWrite=1; with Z=0 PCWrite=0 in BRANCH.
REQ-032 Scenario: CMP R0,#0 (Funct=110101) -> flags load and RegWrite=0 in ALUWB.
REQ-033 Scenario: reset pulled low in MEMWRITE -> MemWrite=0 at once and State=0 on release.
REQ-034 Scenario (MCCTRL_MEMWAIT_EN defined): MemReady=0 for 3 cycles in FETCH -> State holds at 0 and IRWrite=0, then IRWrite=1 on the ready cycle.
